// File: rtl/store_pkg.sv
// Shared encodings for the narrowing store path: request sizes, FSM states,
// and the alignment check used to reject bad requests at accept time.
package store_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  // True when the request cannot be performed: illegal size or misaligned.
  function automatic logic req_is_bad(input size_e size, input logic [1:0] off);
    case (size)
      SZ_BYTE: req_is_bad = 1'b0;
      SZ_HALF: req_is_bad = off[0];
      SZ_WORD: req_is_bad = (off != 2'b00);
      default: req_is_bad = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge: drops byte/half store data into the addressed
// little-endian lanes of the old RAM word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] st_data_i,
  input  logic [1:0]  off_i,
  input  size_e       size_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_word_i;
    case (size_i)
      SZ_BYTE: merged_o[8*off_i +: 8]     = st_data_i[7:0];
      SZ_HALF: merged_o[16*off_i[1] +: 16] = st_data_i[15:0];
      SZ_WORD: merged_o                    = st_data_i;
      default: merged_o                    = old_word_i;
    endcase
  end

endmodule

// File: rtl/store_narrow.sv
// Store narrowing unit: word stores write directly, byte/half stores do a
// read-modify-write of the containing RAM word. Handshake: a request is
// taken on a rising edge where ReqValid && ReqReady; ReqReady is high only in IDLE.
module store_narrow
  import store_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [31:0]       ReqAddr,
  input  logic [31:0]       ReqData,
  input  logic [1:0]        ReqSize,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRdEn,
  input  logic [31:0]       MemRdData,
  output logic              MemWrEn,
  output logic [31:0]       MemWrData,
  output logic              Done,
  output logic              Err,
  output state_e            DbgState
);

  state_e              state_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          off_q;
  logic [31:0]         data_q;
  size_e               size_q;
  logic                ready_q, rd_en_q, wr_en_q, done_q, err_q;
  logic [31:0]         merged_d;
  size_e               req_size;

  assign req_size = size_e'(ReqSize);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      off_q   <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      ready_q <= 1'b1;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ReqValid) begin
            addr_q  <= ReqAddr[ADDR_W+1:2];
            off_q   <= ReqAddr[1:0];
            data_q  <= ReqData;
            size_q  <= req_size;
            ready_q <= 1'b0;
            if (req_is_bad(req_size, ReqAddr[1:0])) begin
              state_q <= ST_FAIL;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state_q <= ST_WRITE;
              wr_en_q <= 1'b1;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          state_q <= ST_MERGE;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b1;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
        end
      endcase
    end
  end

  store_lane_merge u_merge (
    .old_word_i (MemRdData),
    .st_data_i  (data_q),
    .off_i      (off_q),
    .size_i     (size_q),
    .merged_o   (merged_d)
  );

  // Read data only arrives in MERGE, so the merged word cannot be registered.
  assign MemWrData = (state_q == ST_MERGE) ? merged_d :
                     (state_q == ST_WRITE) ? data_q   : 32'h0;

  assign ReqReady = ready_q;
  assign MemAddr  = addr_q;
  assign MemRdEn  = rd_en_q;
  assign MemWrEn  = wr_en_q;
  assign Done     = done_q;
  assign Err      = err_q;
  assign DbgState = state_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^ReqAddr[31:ADDR_W+2];

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-path counterpart to the immediate/load extender: narrows 32-bit register data to byte, halfword or word stores into a word-organised data RAM.
- Sub-word stores use read-modify-write: read the word, merge the target lanes, write it back.
- Sits between the MEM-stage store request and the synchronous data memory.
- Word stores bypass the read.

Parameters:
- ADDR_W, 8, word-index width of the data RAM. Byte address bits [ADDR_W+1:2] select the word.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, asynchronous, active-low.
- ReqValid  in  1  store request valid.
- ReqReady  out  1  block can accept a request (IDLE only).
- ReqAddr  in  32  byte address.
- ReqData  in  32  store data, right-justified.
- ReqSize  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- MemAddr  out  ADDR_W  RAM word index.
- MemRdEn  out  1  RAM read strobe. Data returns on MemRdData the next cycle.
- MemRdData  in  32  RAM read data, one cycle after MemRdEn.
- MemWrEn  out  1  RAM write strobe.
- MemWrData  out  32  RAM write word.
- Done  out  1  one-cycle pulse: request finished.
- Err  out  1  one-cycle pulse with Done: request rejected.

Behaviour:
- Reset: RST low asynchronously forces state IDLE and clears all latched request fields.
  - Outputs under reset: ReqReady=1, MemRdEn=0, MemWrEn=0, Done=0, Err=0, MemAddr=0, MemWrData=0.
- Accept: handshake when ReqValid && ReqReady at a rising edge (cycle T). Addr, data and size are latched; later input changes are ignored.
- States: IDLE, READ, MERGE, WRITE, FAIL. All are one cycle except IDLE.
- IDLE: ReqReady=1. On accept, next state is chosen as follows:
  - size illegal or misaligned (half with addr[0]=1; word with addr[1:0]!=0) -> FAIL.
  - word -> WRITE.
  - byte/half -> READ.
- FAIL (T+1): Done=1, Err=1, no memory strobes -> IDLE.
- WRITE (T+1): MemWrEn=1, MemWrData=latched data, Done=1 -> IDLE.
- READ (T+1): MemRdEn=1 -> MERGE.
- MERGE (T+2): MemWrEn=1, MemWrData=merged word, Done=1 -> IDLE.
- MemAddr = latched ReqAddr[ADDR_W+1:2], held stable throughout READ/MERGE/WRITE.
- Lane mapping is little-endian: lane n = bits [8n+7:8n].
  - Byte store: data[7:0] replaces lane addr[1:0].
  - Half store: data[15:0] replaces lanes {addr[1],0} and {addr[1],1}.
  - All other lanes come from MemRdData.
- Upper ReqData bits beyond the stored size are ignored.
- Next accept is possible at T+2 (word/fail) or T+3 (sub-word). There is no same-cycle re-accept because Done cycles are not IDLE.
- ReqValid held high across completion: the next request is accepted on the first IDLE cycle.
- Reset mid-operation: no write is issued, no Done. The block re-enters IDLE with ReqReady=1 once RST deasserts.
- MemRdEn and MemWrEn are never asserted in the same cycle.

Decomposition:
- Package store_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_BAD.
  - state encoding constants.
  - misalignment-check function.
- Sub-module store_lane_merge: combinational. Inputs: old word, store data, addr[1:0], size. Output: merged word. Instantiated once.

Test Plan:
1. Word store: word 4 holds 0x11223344. sw 0xDEADBEEF to 0x10 -> T+1 MemWrEn=1, MemAddr=4, MemWrData=0xDEADBEEF, Done=1; MemRdEn never 1; ReqReady=1 at T+2.
2. Byte store: sb ReqData=0xFFFFFFAB to 0x12 -> T+1 MemRdEn=1, MemAddr=4; T+2 MemWrData=0x11AB3344, Done=1.
3. Half store: sh 0x1234CAFE to 0x12 -> T+2 MemWrData=0xCAFE3344. sh to 0x10 -> 0x1122CAFE.
4. Errors: sh to 0x13, sw to 0x12, or ReqSize=11 -> T+1 Done=1, Err=1; MemRdEn=MemWrEn=0.
5. Back-to-back: ReqValid held high with two sb (0x10<-0x55, 0x11<-0x66) -> second accepted at T+3; final word 0x11226655.
6. Reset mid-op: RST low during READ of an sb -> no MemWrEn, no Done; after release ReqReady=1 and RAM unchanged.
